pop_sequence_timer: RTL
=======================

// Module: pop_sequence_timer
// PURPOSE
//  POP (pulsed optical pumping) sequence generator clocked by the 2.5 MHz PLL output clk_2M5 (400 ns tick).
//  Emits the repeating pump -> dark -> microwave -> dark -> probe -> gap pulse train on three registered outputs.
//  Reports sequence status to the control logic.
//  Sits directly downstream of the clock block; all timing resolution derives from clk_2M5.
// PARAMETERS
//  CNT_W      16  width of every phase-duration input and of the phase down-counter
//  CYC_W      16  width of n_cycles and cycle_count
// PORTS
//  clk_2M5      in   1      sole clock, 2.5 MHz from PLL
//  rst          in   1      synchronous, active-high reset
//  enable       in   1      level; rising edge starts a sequence (macro-dependent, see CONFIGURATION)
//  stop         in   1      abort request, sampled each edge
//  t_pump       in   CNT_W  pump phase length, in clk_2M5 ticks
//  t_dark       in   CNT_W  length of both dark phases
//  t_mw         in   CNT_W  microwave phase length
//  t_probe      in   CNT_W  probe phase length
//  t_gap        in   CNT_W  inter-cycle gap length
//  n_cycles     in   CYC_W  cycles per run; 0 = continuous
//  ext_trig     in   1      external trigger (used only when POP_EXT_TRIG_EN defined)
//  pump_out     out  1      high during PUMP
//  mw_out       out  1      high during MW
//  probe_out    out  1      high during PROBE
//  busy         out  1      high in any state other than IDLE
//  done         out  1      one-tick pulse on return to IDLE
//  cycle_count  out  CYC_W  completed cycles this run; saturates at all-ones
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; cycle_count 0; phase counter 0; edge-detect history cleared.
//    Reset mid-run drops every output to 0 on the next edge. No done pulse.
//  - FSM states: IDLE, PUMP, DARK1, MW, DARK2, PROBE, GAP.
//    Order: PUMP > DARK1 > MW > DARK2 > PROBE > GAP > PUMP...
//  - Start: a start event is detected at edge N (enable rising, or trigger per CONFIGURATION).
//    * t_* and n_cycles are latched at edge N.
//    * cycle_count is cleared to 0 at edge N.
//    * FSM enters PUMP at edge N; pump_out is high from edge N.
//  - Durations: each phase lasts exactly t_x ticks. A down-counter is loaded with t_x-1 on entry.
//    The FSM leaves the phase on the tick where the counter reads 0.
//    A phase with t_x = 0 is skipped in zero ticks. The next non-zero phase is entered directly.
//    If all t_* = 0, the FSM returns to IDLE at the next edge with done=1 and cycle_count = 0.
//  - Outputs are registered and decoded from the next state, so they are glitch-free.
//    pump_out, mw_out and probe_out are never high simultaneously.
//  - End of GAP: cycle_count increments (saturating). Then:
//    * if n_cycles != 0 and the new count equals n_cycles: go to IDLE, done=1 for one tick;
//    * otherwise: go to PUMP with durations re-latched from the inputs.
//  - enable deasserted mid-run: the current cycle completes through GAP, then IDLE with done=1.
//  - stop high at any edge while busy: IDLE at that edge; outputs 0; done=1; cycle_count holds.
//    * stop coinciding with end of GAP: stop wins, and cycle_count still increments.
//    * stop while IDLE: ignored; no done pulse.
//  - Start events arriving while busy are ignored (no queueing).
//  - Wrap: the phase counter never wraps; it reloads on every phase entry.
//    cycle_count saturates rather than wrapping.
// CONFIGURATION
//  POP_EXT_TRIG_EN defined:
//    * ext_trig passes through a 2-flop synchroniser plus rising-edge detect.
//    * enable high only arms the block; each synchronised ext_trig rising edge starts a run.
//    * Start latency: 3 ticks from the ext_trig transition to pump_out high.
//    * While enable is high, after done the block re-arms for the next trigger.
//  POP_EXT_TRIG_EN undefined:
//    * ext_trig is ignored; the start event is an enable rising edge.
//    * Start latency: 1 tick from the enable transition to pump_out high.
// TESTING
//  1. t_pump=4, t_dark=2, t_mw=3, t_probe=5, t_gap=1, n_cycles=2, pulse enable high ->
//     pump 4 / low 2 / mw 3 / low 2 / probe 5 / low 1, repeated twice;
//     done once on the 34th tick; cycle_count=2.
//  2. t_mw=0 with the other timings from test 1 -> DARK1 goes directly to DARK2;
//     mw_out never rises; cycle length 14 ticks.
//  3. n_cycles=0, stop asserted on tick 7 of the second cycle -> all outputs 0 next edge;
//     done=1; cycle_count=1.
//  4. rst asserted during PROBE -> all outputs 0 and cycle_count=0 next edge;
//     no done; re-start behaves as test 1.
//  5. enable dropped during MW of cycle 1 with n_cycles=0 -> cycle 1 finishes;
//     done after GAP; cycle_count=1.
//  6. POP_EXT_TRIG_EN defined, enable=1, ext_trig pulse -> pump_out high 3 ticks later;
//     a second trigger while busy is ignored.

Source files
------------

// File: rtl/pop_sequence_timer.sv
`timescale 1ns/1ps
// pop_sequence_timer: repeating pump/dark/mw/dark/probe/gap pulse train on the 2.5 MHz clk_2M5.
// Build option POP_EXT_TRIG_EN: enable only arms, synchronised ext_trig rising edges start runs.
module pop_sequence_timer #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned CYC_W = 16
) (
    input  logic             clk_2M5,
    input  logic             rst,
    input  logic             enable,
    input  logic             stop,
    input  logic [CNT_W-1:0] t_pump,
    input  logic [CNT_W-1:0] t_dark,
    input  logic [CNT_W-1:0] t_mw,
    input  logic [CNT_W-1:0] t_probe,
    input  logic [CNT_W-1:0] t_gap,
    input  logic [CYC_W-1:0] n_cycles,
    input  logic             ext_trig,
    output logic             pump_out,
    output logic             mw_out,
    output logic             probe_out,
    output logic             busy,
    output logic             done,
    output logic [CYC_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PUMP  = 3'd1,
        DARK1 = 3'd2,
        MW    = 3'd3,
        DARK2 = 3'd4,
        PROBE = 3'd5,
        GAP   = 3'd6
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] l_pump, l_dark, l_mw, l_probe, l_gap;
    logic [CYC_W-1:0] l_ncyc;
    logic             quit;
    logic             start_ev;

`ifdef POP_EXT_TRIG_EN
    // two-flop synchroniser plus one history flop for rising-edge detect
    logic [2:0] trig_sync;
    always_ff @(posedge clk_2M5) begin
        if (rst) trig_sync <= '0;
        else     trig_sync <= {trig_sync[1:0], ext_trig};
    end
    assign start_ev = enable && trig_sync[1] && !trig_sync[2];
`else
    logic enable_q;
    logic unused_ext_trig;
    always_ff @(posedge clk_2M5) begin
        if (rst) enable_q <= 1'b0;
        else     enable_q <= enable;
    end
    assign start_ev        = enable && !enable_q;
    assign unused_ext_trig = ext_trig;
`endif

    function automatic logic [CNT_W-1:0] dur_of(input logic [2:0] ph,
                                                input logic [CNT_W-1:0] tp, td, tm, tpr, tg);
        case (ph)
            3'd1:       dur_of = tp;
            3'd2, 3'd4: dur_of = td;
            3'd3:       dur_of = tm;
            3'd5:       dur_of = tpr;
            3'd6:       dur_of = tg;
            default:    dur_of = '0;
        endcase
    endfunction

    // first phase at or after 'from' with a non-zero length; 0 when none remain in the cycle
    function automatic logic [2:0] first_phase(input logic [2:0] from,
                                               input logic [CNT_W-1:0] tp, td, tm, tpr, tg);
        logic [2:0] hit;
        hit = 3'd0;
        for (int i = 6; i >= 1; i--) begin
            if (3'(i) >= from && dur_of(3'(i), tp, td, tm, tpr, tg) != '0) hit = 3'(i);
        end
        return hit;
    endfunction

    logic [2:0]       nxt_same_c, nxt_new_c;
    logic [CNT_W-1:0] same_dur_c, new_dur_c;
    logic [CYC_W-1:0] count_inc_c;
    logic             lat_zero_c, cycle_end_c, n_hit_c, relatch_c;

    always_comb begin
        nxt_same_c  = first_phase(3'(state) + 3'd1, l_pump, l_dark, l_mw, l_probe, l_gap);
        nxt_new_c   = first_phase(3'd1, t_pump, t_dark, t_mw, t_probe, t_gap);
        same_dur_c  = dur_of(nxt_same_c, l_pump, l_dark, l_mw, l_probe, l_gap);
        new_dur_c   = dur_of(nxt_new_c, t_pump, t_dark, t_mw, t_probe, t_gap);
        lat_zero_c  = (l_pump | l_dark | l_mw | l_probe | l_gap) == '0;
        cycle_end_c = (state != IDLE) && (cnt == '0) && (nxt_same_c == 3'd0) && !lat_zero_c;
        count_inc_c = (&cycle_count) ? cycle_count : cycle_count + CYC_W'(1);
        n_hit_c     = (l_ncyc != '0) && (count_inc_c == l_ncyc);
        relatch_c   = (state == IDLE) ? start_ev
                                      : (cycle_end_c && !stop && !quit && enable && !n_hit_c);
    end

    // All-zero durations park in PUMP with outputs low for one tick, then finish without counting.
    always_ff @(posedge clk_2M5) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            l_pump      <= '0;
            l_dark      <= '0;
            l_mw        <= '0;
            l_probe     <= '0;
            l_gap       <= '0;
            l_ncyc      <= '0;
            quit        <= 1'b0;
            pump_out    <= 1'b0;
            mw_out      <= 1'b0;
            probe_out   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
        end else begin
            done <= 1'b0;
            if (relatch_c) begin
                l_pump    <= t_pump;
                l_dark    <= t_dark;
                l_mw      <= t_mw;
                l_probe   <= t_probe;
                l_gap     <= t_gap;
                state     <= (nxt_new_c == 3'd0) ? PUMP : state_t'(nxt_new_c);
                cnt       <= (nxt_new_c == 3'd0) ? '0 : new_dur_c - CNT_W'(1);
                pump_out  <= (nxt_new_c == 3'(PUMP));
                mw_out    <= (nxt_new_c == 3'(MW));
                probe_out <= (nxt_new_c == 3'(PROBE));
                busy      <= 1'b1;
                if (state == IDLE) begin
                    l_ncyc      <= n_cycles;
                    cycle_count <= '0;
                    quit        <= 1'b0;
                end else begin
                    cycle_count <= count_inc_c;
                end
            end else if (state != IDLE) begin
                if (stop || lat_zero_c || cycle_end_c) begin
                    state     <= IDLE;
                    cnt       <= '0;
                    pump_out  <= 1'b0;
                    mw_out    <= 1'b0;
                    probe_out <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    if (cycle_end_c) cycle_count <= count_inc_c;
                end else begin
                    if (!enable) quit <= 1'b1;
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state     <= state_t'(nxt_same_c);
                        cnt       <= same_dur_c - CNT_W'(1);
                        pump_out  <= (nxt_same_c == 3'(PUMP));
                        mw_out    <= (nxt_same_c == 3'(MW));
                        probe_out <= (nxt_same_c == 3'(PROBE));
                    end
                end
            end
        end
    end

endmodule
